// File: rtl/ground_tex_fetch_if.sv
// ground_tex_fetch_if
//   Synchronous read port of the 256x3-bit ground texture ROM.
//   master (fetch block): drives rom_en / rom_addr, receives rom_data.
//   slave  (ROM):         receives rom_en / rom_addr, returns rom_data
//                         registered one cycle after the address.
//   Ports:
//     rom_en    1   read enable
//     rom_addr  8   {row[3:0], col[3:0]}
//     rom_data  3   palette index
interface ground_tex_fetch_if;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [2:0] rom_data;

  modport master (output rom_en, output rom_addr, input rom_data);
  modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/ground_tex_fetch.sv
// ground_tex_fetch
//   Converts the pixel coordinate plus the per-frame scroll distance into a
//   16x16 ground tile address, reads the texture ROM and maps the returned
//   palette index to 12-bit RGB. Pixel sideband is delayed 3 cycles to line
//   up with the colour.
//   Ports:
//     clk, rst_n     pixel clock, asynchronous active-low reset
//     pix_x, pix_y   current pixel coordinate (10 bits each)
//     pix_valid      pixel is in the active area
//     frame_tick     one-cycle pulse per frame (vertical blank)
//     run, speed     scroll enable and pixels advanced per frame
//     rom            ROM read port (master side)
//     out_valid      pix_valid delayed 3 cycles
//     out_ground     pixel in the ground band, delayed 3 cycles
//     out_rgb        4:4:4 colour, 0x000 outside the ground band
//     distance       total scrolled pixels, saturating at 0xFFFF
module ground_tex_fetch #(
  parameter logic [9:0] GROUND_Y = 10'd400
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9:0]                pix_x,
  input  logic [9:0]                pix_y,
  input  logic                      pix_valid,
  input  logic                      frame_tick,
  input  logic                      run,
  input  logic [2:0]                speed,
  ground_tex_fetch_if.master        rom,
  output logic                      out_valid,
  output logic                      out_ground,
  output logic [11:0]               out_rgb,
  output logic [15:0]               distance
);

  logic        ground;
  logic [9:0]  row_off;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [16:0] dist_sum;
  logic        valid1, ground1;
  logic        valid2, ground2;
  logic [11:0] pal_rgb;

  assign ground   = pix_valid && (pix_y >= GROUND_Y);
  assign row_off  = pix_y - GROUND_Y;
  // Rows below the first tile repeat the last tile row.
  assign row      = (row_off < 10'd16) ? row_off[3:0] : 4'hF;
  // 4-bit add wraps the column around the tile on purpose.
  assign col      = pix_x[3:0] + distance[3:0];
  assign dist_sum = {1'b0, distance} + {14'd0, speed};

  always_comb begin
    pal_rgb = 12'h000;
    case (rom.rom_data)
      3'd0: pal_rgb = 12'h742;
      3'd1: pal_rgb = 12'h5C3;
      3'd2: pal_rgb = 12'h3A2;
      3'd3: pal_rgb = 12'h963;
      3'd4: pal_rgb = 12'h7E4;
      3'd5: pal_rgb = 12'hB85;
      3'd6: pal_rgb = 12'hDA6;
      3'd7: pal_rgb = 12'hFFF;
      default: pal_rgb = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      distance <= 16'h0000;
    end else if (frame_tick && run) begin
      distance <= dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
    end
  end

  // Stage 1: address. rom_addr holds outside the band so the ROM port
  // stays quiet between lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom.rom_en   <= 1'b0;
      rom.rom_addr <= 8'h00;
      valid1       <= 1'b0;
      ground1      <= 1'b0;
    end else begin
      rom.rom_en <= ground;
      valid1     <= pix_valid;
      ground1    <= ground;
      if (ground) begin
        rom.rom_addr <= {row, col};
      end
    end
  end

  // Stage 2: flags travel alongside the ROM's internal data register.
  // Stage 3: colour. ground2 masks any stale rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid2     <= 1'b0;
      ground2    <= 1'b0;
      out_valid  <= 1'b0;
      out_ground <= 1'b0;
      out_rgb    <= 12'h000;
    end else begin
      valid2     <= valid1;
      ground2    <= ground1;
      out_valid  <= valid2;
      out_ground <= ground2;
      out_rgb    <= ground2 ? pal_rgb : 12'h000;
    end
  end

endmodule

// File: tb/tb_ground_tex_fetch.sv
module tb_ground_tex_fetch;

  typedef struct {
    logic        v;
    logic        g;
    logic [11:0] rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       pix_valid = 1'b0;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic [2:0] speed = '0;
  logic       out_valid, out_ground;
  logic [11:0] out_rgb;
  logic [15:0] distance;

  ground_tex_fetch_if bus ();

  ground_tex_fetch #(.GROUND_Y(10'd400)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .frame_tick (frame_tick),
    .run        (run),
    .speed      (speed),
    .rom        (bus),
    .out_valid  (out_valid),
    .out_ground (out_ground),
    .out_rgb    (out_rgb),
    .distance   (distance)
  );

  always #5 clk = ~clk;

  logic [2:0]  rom_mem [256];
  logic [11:0] pal_t [8] = '{12'h742, 12'h5C3, 12'h3A2, 12'h963,
                             12'h7E4, 12'hB85, 12'hDA6, 12'hFFF};

  // ROM with a registered read port
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_mem[bus.rom_addr];
  end

  int   checks = 0;
  int   errors = 0;
  int   m_dist;
  int   m_addr;
  exp_t q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z.v = 1'b0; z.g = 1'b0; z.rgb = 12'h000;
    m_dist = 0;
    m_addr = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic drive(int x, int y, logic v);
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = v;
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic step();
    exp_t e;
    int   r, row, col;
    logic g;
    g = pix_valid && (int'(pix_y) >= 400);
    r = int'(pix_y) - 400;
    row = (r >= 0 && r < 16) ? r : 15;
    col = (int'(pix_x) % 16 + m_dist % 16) % 16;
    if (g) m_addr = row * 16 + col;
    e.v   = pix_valid;
    e.g   = g;
    e.rgb = g ? pal_t[rom_mem[m_addr]] : 12'h000;
    q.push_back(e);
    if (frame_tick && run) begin
      m_dist = m_dist + int'(speed);
      if (m_dist > 65535) m_dist = 65535;
    end
    @(posedge clk);
    #1;
    check("rom_en", 32'(bus.rom_en), 32'(g));
    check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
    check("distance", 32'(distance), 32'(m_dist));
    e = q.pop_front();
    check("out_valid", 32'(out_valid), 32'(e.v));
    check("out_ground", 32'(out_ground), 32'(e.g));
    check("out_rgb", 32'(out_rgb), 32'(e.rgb));
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rom_en"}, 32'(bus.rom_en), 32'd0);
    check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_ground"}, 32'(out_ground), 32'd0);
    check({tag, "_out_rgb"}, 32'(out_rgb), 32'd0);
    check({tag, "_distance"}, 32'(distance), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    rom_mem[3] = 3'd1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Basic fetch
    drive(3, 400, 1'b1);
    step();
    check("basic_addr", 32'(bus.rom_addr), 32'h03);
    check("basic_en", 32'(bus.rom_en), 32'd1);
    drive(0, 0, 1'b0);
    step();
    step();
    check("basic_rgb", 32'(out_rgb), 32'h5C3);
    check("basic_ground", 32'(out_ground), 32'd1);

    // Row clamp and band edge
    drive(5, 440, 1'b1);
    step();
    check("clamp_addr", 32'(bus.rom_addr), 32'hF5);
    drive(5, 399, 1'b1);
    repeat (3) step();
    check("edge_en", 32'(bus.rom_en), 32'd0);
    check("edge_valid", 32'(out_valid), 32'd1);
    check("edge_ground", 32'(out_ground), 32'd0);
    check("edge_rgb", 32'(out_rgb), 32'h000);

    // Streaming then blanking, scroll 0
    for (int x = 0; x < 32; x++) begin
      drive(x, 405, 1'b1);
      step();
    end
    drive(0, 405, 1'b0);
    repeat (4) step();
    check("blank_valid", 32'(out_valid), 32'd0);
    check("blank_rgb", 32'(out_rgb), 32'h000);

    // Scroll and wrap
    run = 1'b1; speed = 3'd3; frame_tick = 1'b1;
    repeat (6) step();
    frame_tick = 1'b0;
    check("scroll_dist", 32'(distance), 32'd18);
    drive(14, 402, 1'b1);
    step();
    check("wrap_addr", 32'(bus.rom_addr), 32'h20);
    drive(0, 0, 1'b0);
    run = 1'b0; frame_tick = 1'b1;
    repeat (3) step();
    frame_tick = 1'b0;
    check("norun_dist", 32'(distance), 32'd18);

    // Randomised traffic, ticks landing while pixels are in flight
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1023), $urandom_range(390, 450), 1'($urandom_range(0, 3) != 0));
      frame_tick = ($urandom_range(0, 7) == 0);
      run        = 1'($urandom_range(0, 1));
      speed      = 3'($urandom_range(0, 7));
      step();
    end
    frame_tick = 1'b0;

    // Asynchronous reset between edges, mid-stream
    drive(7, 403, 1'b1);
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("async_hold");
    @(negedge clk);
    rst_n = 1'b1;
    drive(9, 404, 1'b1);
    step();
    check("resume_en", 32'(bus.rom_en), 32'd1);
    check("resume_early", 32'(out_valid), 32'd0);
    step();
    check("resume_early2", 32'(out_valid), 32'd0);
    step();
    check("resume_valid", 32'(out_valid), 32'd1);

    // Saturation
    drive(0, 0, 1'b0);
    run = 1'b1; speed = 3'd7; frame_tick = 1'b1;
    repeat (9362) step();
    check("sat_pre", 32'(distance), 32'hFFFE);
    step();
    check("sat_hit", 32'(distance), 32'hFFFF);
    step();
    check("sat_hold", 32'(distance), 32'hFFFF);
    frame_tick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
